// File: rtl/serdesphy_pkg.sv
// Shared types and default timing for the SerDes PHY link bring-up sequencer.
package serdesphy_pkg;

  // Default timing at the 24 MHz reference.
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_SETTLE_CYC = 24;
  localparam int unsigned DEF_PLL_TMO    = 4800;  // 200 us
  localparam int unsigned DEF_CDR_TMO    = 2400;  // 100 us
  localparam int unsigned DEF_MAX_RETRY  = 3;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  // Sequencer state; the codes are visible on seq_state.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_PLL_RST  = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_TX_ON    = 3'd3,
    ST_CDR_WAIT = 3'd4,
    ST_ALIGN    = 3'd5,
    ST_READY    = 3'd6,
    ST_FAULT    = 3'd7
  } seq_state_t;

  // Level controls toward the PMA, all a pure function of state.
  typedef struct packed {
    logic pll_enable;
    logic pll_rst;
    logic tx_en;
    logic rx_en;
    logic cdr_rst;
    logic phy_ready;
    logic seq_error;
  } pma_ctrl_t;

  // Everything held in reset: PLL and CDR resets asserted, enables off.
  localparam pma_ctrl_t CTRL_OFF = '{
    pll_enable: 1'b0,
    pll_rst:    1'b1,
    tx_en:      1'b0,
    rx_en:      1'b0,
    cdr_rst:    1'b1,
    phy_ready:  1'b0,
    seq_error:  1'b0
  };

  // Moore decode of the PMA controls for a given state.
  function automatic pma_ctrl_t ctrl_decode(input seq_state_t st);
    pma_ctrl_t c;
    c = CTRL_OFF;
    case (st)
      ST_PLL_RST: begin
        c.pll_enable = 1'b1;
      end
      ST_PLL_WAIT: begin
        c.pll_enable = 1'b1;
        c.pll_rst    = 1'b0;
      end
      ST_TX_ON: begin
        c.pll_enable = 1'b1;
        c.pll_rst    = 1'b0;
        c.tx_en      = 1'b1;
      end
      ST_CDR_WAIT, ST_ALIGN: begin
        c.pll_enable = 1'b1;
        c.pll_rst    = 1'b0;
        c.tx_en      = 1'b1;
        c.rx_en      = 1'b1;
        c.cdr_rst    = 1'b0;
      end
      ST_READY: begin
        c.pll_enable = 1'b1;
        c.pll_rst    = 1'b0;
        c.tx_en      = 1'b1;
        c.rx_en      = 1'b1;
        c.cdr_rst    = 1'b0;
        c.phy_ready  = 1'b1;
      end
      ST_FAULT: begin
        c.seq_error  = 1'b1;
      end
      default: begin
        c = CTRL_OFF;
      end
    endcase
    return c;
  endfunction

  // Largest of three timing constants, used to size-check the counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/serdesphy_seq_timer.sv
// Shared settle/timeout counter: loadable up-counter with clear and terminal-count compare.
module serdesphy_seq_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  // Count cycles in the current state; clear wins over load, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == tc_val);

endmodule

// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up sequencer: PLL, TX, CDR and word-align ordering with retry.
module serdesphy_link_seq
  import serdesphy_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned PLL_TMO    = DEF_PLL_TMO,
  parameter int unsigned CDR_TMO    = DEF_CDR_TMO,
  parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic               clk_ref_24m,
  input  logic               rst_n,
  input  logic               power_good,
  input  logic               phy_en,
  input  logic               pll_lock,
  input  logic               cdr_lock,
  input  logic               rx_aligned,
  output logic               pll_enable,
  output logic               pll_rst,
  output logic               tx_en,
  output logic               rx_en,
  output logic               cdr_rst,
  output logic               rx_align_rst,
  output logic               phy_ready,
  output logic               seq_error,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] seq_state
);

  localparam int unsigned MAX_CYC  = max3(SETTLE_CYC, PLL_TMO, CDR_TMO);
  localparam bit          CNT_FITS = (CNT_W >= 32) || ((MAX_CYC >> CNT_W) == 0);

  // Elaboration guards on the parameter set.
  if (!CNT_FITS) begin : g_cnt_w_check
    $error("serdesphy_link_seq: CNT_W too narrow for the largest timing parameter");
  end
  if (MAX_RETRY > 3) begin : g_retry_check
    $error("serdesphy_link_seq: MAX_RETRY does not fit in retry_cnt");
  end
  if (SETTLE_CYC == 0 || PLL_TMO == 0 || CDR_TMO == 0) begin : g_zero_check
    $error("serdesphy_link_seq: timing parameters must be non-zero");
  end

  seq_state_t         state;
  seq_state_t         nxt_state;
  seq_state_t         retry_target;
  logic [RETRY_W-1:0] nxt_retry;
  logic [CNT_W-1:0]   tc_val;
  logic               tc;
  logic               timeout;
  logic               state_chg;
  pma_ctrl_t          ctrl_q;

  // Terminal count for the timed states; the counter starts at 0 on entry.
  always_comb begin
    tc_val = {CNT_W{1'b1}};
    case (state)
      ST_PLL_RST, ST_TX_ON:  tc_val = CNT_W'(SETTLE_CYC - 1);
      ST_PLL_WAIT:           tc_val = CNT_W'(PLL_TMO - 1);
      ST_CDR_WAIT, ST_ALIGN: tc_val = CNT_W'(CDR_TMO - 1);
      default:               tc_val = {CNT_W{1'b1}};
    endcase
  end

  assign state_chg = (nxt_state != state);

  serdesphy_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk_ref_24m),
    .rst_n    (rst_n),
    .clr      (state_chg),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .tc_val   (tc_val),
    .tc_c     (tc)
  );

  // Next state and retry count; override first, lock beats timeout in the same cycle.
  always_comb begin
    nxt_state    = state;
    nxt_retry    = retry_cnt;
    timeout      = 1'b0;
    retry_target = ST_PLL_RST;
    if (!power_good || !phy_en) begin
      nxt_state = ST_OFF;
      nxt_retry = '0;
    end else begin
      case (state)
        ST_OFF: begin
          nxt_state = ST_PLL_RST;
        end
        ST_PLL_RST: begin
          if (tc) nxt_state = ST_PLL_WAIT;
        end
        ST_PLL_WAIT: begin
          if (pll_lock) nxt_state = ST_TX_ON;
          else if (tc)  timeout   = 1'b1;
        end
        ST_TX_ON: begin
          if (tc) nxt_state = ST_CDR_WAIT;
        end
        ST_CDR_WAIT: begin
          if (cdr_lock) nxt_state = ST_ALIGN;
          else if (tc)  timeout   = 1'b1;
        end
        ST_ALIGN: begin
          if (rx_aligned) nxt_state = ST_READY;
          else if (tc)    timeout   = 1'b1;
        end
        ST_READY: begin
          // Losing PLL lock restarts from PLL reset; losing only CDR lock re-acquires the CDR.
          if (!pll_lock) begin
            timeout      = 1'b1;
            retry_target = ST_PLL_RST;
          end else if (!cdr_lock) begin
            timeout      = 1'b1;
            retry_target = ST_CDR_WAIT;
          end
        end
        ST_FAULT: begin
          nxt_state = ST_FAULT;
        end
        default: begin
          nxt_state = ST_OFF;
        end
      endcase

      if (timeout) begin
        if (32'(retry_cnt) < MAX_RETRY) begin
          nxt_state = retry_target;
          if (retry_cnt != {RETRY_W{1'b1}}) nxt_retry = retry_cnt + RETRY_W'(1);
        end else begin
          nxt_state = ST_FAULT;
        end
      end
    end
  end

  // State, retry count and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_OFF;
      retry_cnt    <= '0;
      ctrl_q       <= CTRL_OFF;
      rx_align_rst <= 1'b0;
    end else begin
      state        <= nxt_state;
      retry_cnt    <= nxt_retry;
      ctrl_q       <= ctrl_decode(nxt_state);
      rx_align_rst <= (nxt_state == ST_ALIGN) && (state != ST_ALIGN);
    end
  end

  assign pll_enable = ctrl_q.pll_enable;
  assign pll_rst    = ctrl_q.pll_rst;
  assign tx_en      = ctrl_q.tx_en;
  assign rx_en      = ctrl_q.rx_en;
  assign cdr_rst    = ctrl_q.cdr_rst;
  assign phy_ready  = ctrl_q.phy_ready;
  assign seq_error  = ctrl_q.seq_error;
  assign seq_state  = state;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Directed bench for serdesphy_link_seq with shortened timing.
module tb_serdesphy_link_seq;

  logic       clk_ref_24m = 1'b0;
  logic       rst_n;
  logic       power_good;
  logic       phy_en;
  logic       pll_lock;
  logic       cdr_lock;
  logic       rx_aligned;
  logic       pll_enable;
  logic       pll_rst;
  logic       tx_en;
  logic       rx_en;
  logic       cdr_rst;
  logic       rx_align_rst;
  logic       phy_ready;
  logic       seq_error;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  int checks   = 0;
  int failures = 0;

  // {pll_enable, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready, seq_error}
  localparam logic [7:0] O_OFF    = 8'b0100_1000;
  localparam logic [7:0] O_PRST   = 8'b1100_1000;
  localparam logic [7:0] O_PWAIT  = 8'b1000_1000;
  localparam logic [7:0] O_TXON   = 8'b1010_1000;
  localparam logic [7:0] O_CDRW   = 8'b1011_0000;
  localparam logic [7:0] O_ALIGN1 = 8'b1011_0100;
  localparam logic [7:0] O_ALIGN0 = 8'b1011_0000;
  localparam logic [7:0] O_READY  = 8'b1011_0010;
  localparam logic [7:0] O_FAULT  = 8'b0100_1001;

  wire [7:0] outs = {pll_enable, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready, seq_error};

  always #5 clk_ref_24m = ~clk_ref_24m;

  serdesphy_link_seq #(
    .CNT_W      (16),
    .SETTLE_CYC (4),
    .PLL_TMO    (20),
    .CDR_TMO    (10),
    .MAX_RETRY  (3)
  ) dut (
    .clk_ref_24m  (clk_ref_24m),
    .rst_n        (rst_n),
    .power_good   (power_good),
    .phy_en       (phy_en),
    .pll_lock     (pll_lock),
    .cdr_lock     (cdr_lock),
    .rx_aligned   (rx_aligned),
    .pll_enable   (pll_enable),
    .pll_rst      (pll_rst),
    .tx_en        (tx_en),
    .rx_en        (rx_en),
    .cdr_rst      (cdr_rst),
    .rx_align_rst (rx_align_rst),
    .phy_ready    (phy_ready),
    .seq_error    (seq_error),
    .retry_cnt    (retry_cnt),
    .seq_state    (seq_state)
  );

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ref_24m);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; power_good = 1'b0; phy_en = 1'b0;
    pll_lock = 1'b0; cdr_lock = 1'b0; rx_aligned = 1'b0;
    #12;
    checks++;
    if (seq_state !== 3'd0 || outs !== O_OFF || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset state=%0d outs=%b retry=%0d required state=0 outs=%b retry=0", seq_state, outs, retry_cnt, O_OFF);
    end
    @(negedge clk_ref_24m);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd0 || outs !== O_OFF) begin
      failures++;
      $display("FAIL off_no_power state=%0d outs=%b required state=0 outs=%b", seq_state, outs, O_OFF);
    end
  endtask

  task automatic test_happy_path();
    power_good = 1'b1; phy_en = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd1 || outs !== O_PRST) begin
      failures++;
      $display("FAIL happy_pll_rst state=%0d outs=%b required state=1 outs=%b", seq_state, outs, O_PRST);
    end
    tick(3);
    checks++;
    if (seq_state !== 3'd1) begin
      failures++;
      $display("FAIL happy_settle_last state=%0d required 1", seq_state);
    end
    tick(1);
    checks++;
    if (seq_state !== 3'd2 || outs !== O_PWAIT) begin
      failures++;
      $display("FAIL happy_pll_wait state=%0d outs=%b required state=2 outs=%b", seq_state, outs, O_PWAIT);
    end
    tick(5);
    checks++;
    if (seq_state !== 3'd2) begin
      failures++;
      $display("FAIL happy_pll_wait_hold state=%0d required 2", seq_state);
    end
    pll_lock = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd3 || outs !== O_TXON) begin
      failures++;
      $display("FAIL happy_tx_on state=%0d outs=%b required state=3 outs=%b", seq_state, outs, O_TXON);
    end
    tick(3);
    checks++;
    if (seq_state !== 3'd3) begin
      failures++;
      $display("FAIL happy_tx_settle_last state=%0d required 3", seq_state);
    end
    tick(1);
    checks++;
    if (seq_state !== 3'd4 || outs !== O_CDRW) begin
      failures++;
      $display("FAIL happy_cdr_wait state=%0d outs=%b required state=4 outs=%b", seq_state, outs, O_CDRW);
    end
    tick(5);
    cdr_lock = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd5 || outs !== O_ALIGN1) begin
      failures++;
      $display("FAIL happy_align_first state=%0d outs=%b required state=5 outs=%b", seq_state, outs, O_ALIGN1);
    end
    tick(1);
    checks++;
    if (seq_state !== 3'd5 || outs !== O_ALIGN0) begin
      failures++;
      $display("FAIL happy_align_pulse_end state=%0d outs=%b required state=5 outs=%b", seq_state, outs, O_ALIGN0);
    end
    tick(1);
    rx_aligned = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd6 || outs !== O_READY || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL happy_ready state=%0d outs=%b retry=%0d required state=6 outs=%b retry=0", seq_state, outs, retry_cnt, O_READY);
    end
  endtask

  task automatic test_cdr_drop();
    cdr_lock = 1'b0;
    tick(1);
    checks++;
    if (seq_state !== 3'd4 || outs !== O_CDRW || retry_cnt !== 2'd1) begin
      failures++;
      $display("FAIL cdr_drop_wait state=%0d outs=%b retry=%0d required state=4 outs=%b retry=1", seq_state, outs, retry_cnt, O_CDRW);
    end
    cdr_lock = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd5 || outs !== O_ALIGN1) begin
      failures++;
      $display("FAIL cdr_drop_align state=%0d outs=%b required state=5 outs=%b", seq_state, outs, O_ALIGN1);
    end
    tick(1);
    checks++;
    if (seq_state !== 3'd6 || outs !== O_READY || retry_cnt !== 2'd1) begin
      failures++;
      $display("FAIL cdr_drop_ready state=%0d outs=%b retry=%0d required state=6 outs=%b retry=1", seq_state, outs, retry_cnt, O_READY);
    end
  endtask

  task automatic test_power_drop();
    cdr_lock = 1'b0;
    tick(3);
    checks++;
    if (seq_state !== 3'd4 || retry_cnt !== 2'd2) begin
      failures++;
      $display("FAIL pwr_pre_cdr_wait state=%0d retry=%0d required state=4 retry=2", seq_state, retry_cnt);
    end
    power_good = 1'b0;
    tick(1);
    checks++;
    if (seq_state !== 3'd0 || outs !== O_OFF || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL pwr_drop_off state=%0d outs=%b retry=%0d required state=0 outs=%b retry=0", seq_state, outs, retry_cnt, O_OFF);
    end
    pll_lock = 1'b0; rx_aligned = 1'b0;
    tick(2);
    checks++;
    if (seq_state !== 3'd0) begin
      failures++;
      $display("FAIL pwr_off_hold state=%0d required 0", seq_state);
    end
  endtask

  task automatic test_pll_timeout();
    power_good = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd1 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL tmo_start state=%0d retry=%0d required state=1 retry=0", seq_state, retry_cnt);
    end
    tick(4);
    for (int k = 1; k <= 4; k++) begin
      tick(19);
      checks++;
      if (seq_state !== 3'd2 || retry_cnt !== 2'(k - 1)) begin
        failures++;
        $display("FAIL tmo_wait_last round=%0d state=%0d retry=%0d required state=2 retry=%0d", k, seq_state, retry_cnt, k - 1);
      end
      tick(1);
      if (k < 4) begin
        checks++;
        if (seq_state !== 3'd1 || outs !== O_PRST || retry_cnt !== 2'(k)) begin
          failures++;
          $display("FAIL tmo_retry round=%0d state=%0d outs=%b retry=%0d required state=1 outs=%b retry=%0d", k, seq_state, outs, retry_cnt, O_PRST, k);
        end
        tick(4);
      end
    end
    checks++;
    if (seq_state !== 3'd7 || outs !== O_FAULT || retry_cnt !== 2'd3) begin
      failures++;
      $display("FAIL tmo_fault state=%0d outs=%b retry=%0d required state=7 outs=%b retry=3", seq_state, outs, retry_cnt, O_FAULT);
    end
    pll_lock = 1'b1;
    tick(3);
    checks++;
    if (seq_state !== 3'd7 || seq_error !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky state=%0d seq_error=%b required state=7 seq_error=1", seq_state, seq_error);
    end
  endtask

  task automatic test_fault_recover();
    phy_en = 1'b0; pll_lock = 1'b0;
    tick(1);
    checks++;
    if (seq_state !== 3'd0 || outs !== O_OFF || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL recover_off state=%0d outs=%b retry=%0d required state=0 outs=%b retry=0", seq_state, outs, retry_cnt, O_OFF);
    end
    phy_en = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd1) begin
      failures++;
      $display("FAIL recover_pll_rst state=%0d required 1", seq_state);
    end
    tick(4);
    checks++;
    if (seq_state !== 3'd2) begin
      failures++;
      $display("FAIL recover_pll_wait state=%0d required 2", seq_state);
    end
    tick(19);
    pll_lock = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd3 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL lock_beats_timeout state=%0d retry=%0d required state=3 retry=0", seq_state, retry_cnt);
    end
    tick(4);
    cdr_lock = 1'b1;
    tick(1);
    checks++;
    if (seq_state !== 3'd5 || outs !== O_ALIGN1) begin
      failures++;
      $display("FAIL recover_align state=%0d outs=%b required state=5 outs=%b", seq_state, outs, O_ALIGN1);
    end
  endtask

  task automatic test_async_reset();
    tick(1);
    checks++;
    if (seq_state !== 3'd5 || outs !== O_ALIGN0) begin
      failures++;
      $display("FAIL areset_pre state=%0d outs=%b required state=5 outs=%b", seq_state, outs, O_ALIGN0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seq_state !== 3'd0 || outs !== O_OFF || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL areset_immediate state=%0d outs=%b retry=%0d required state=0 outs=%b retry=0", seq_state, outs, retry_cnt, O_OFF);
    end
    @(negedge clk_ref_24m);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_cdr_drop();
    test_power_drop();
    test_pll_timeout();
    test_fault_recover();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
